// File: rtl/tl_pkg.sv
// Shared TileLink-UH definitions for the SRAM responder: opcodes, widths,
// FSM state encoding, D-channel header struct and burst-length helpers.
package tl_pkg;

    localparam int TL_OP_W     = 3;
    localparam int TL_SIZE_W   = 4;
    localparam int TL_DPARAM_W = 2;
    // lg2 size can reach 15, i.e. 4096 beats of 8 bytes, so the count needs 13 bits
    localparam int TL_BEAT_W   = 13;

    localparam logic [TL_OP_W-1:0] A_PUT_FULL    = 3'd0;
    localparam logic [TL_OP_W-1:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [TL_OP_W-1:0] A_ARITH       = 3'd2;
    localparam logic [TL_OP_W-1:0] A_LOGICAL     = 3'd3;
    localparam logic [TL_OP_W-1:0] A_GET         = 3'd4;
    localparam logic [TL_OP_W-1:0] A_HINT        = 3'd5;

    localparam logic [TL_OP_W-1:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [TL_OP_W-1:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [TL_OP_W-1:0] D_HINT_ACK        = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ACK,
        ST_RD_ISSUE,
        ST_RD_RESP
    } state_e;

    typedef struct packed {
        logic [TL_OP_W-1:0]     opcode;
        logic [TL_DPARAM_W-1:0] param;
        logic [TL_SIZE_W-1:0]   size;
        logic                   denied;
        logic                   corrupt;
    } d_hdr_t;

    function automatic logic [TL_BEAT_W-1:0] beats_from_size(input logic [TL_SIZE_W-1:0] size);
        if (size <= 4'd3) begin
            return TL_BEAT_W'(1);
        end
        return TL_BEAT_W'(1) << (size - 4'd3);
    endfunction

    function automatic logic is_put(input logic [TL_OP_W-1:0] op);
        return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL);
    endfunction

endpackage

// File: rtl/tl_sram_responder_if.sv
// A/D channel bundle between the coupler (master) and the SRAM responder (slave).
interface tl_sram_responder_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int SOURCE_W = 1,
    parameter int SINK_W   = 2
);
    logic                  in_a_ready;
    logic                  in_a_valid;
    logic [2:0]            in_a_bits_opcode;
    logic [2:0]            in_a_bits_param;
    logic [3:0]            in_a_bits_size;
    logic [SOURCE_W-1:0]   in_a_bits_source;
    logic [ADDR_W-1:0]     in_a_bits_address;
    logic [DATA_W/8-1:0]   in_a_bits_mask;
    logic [DATA_W-1:0]     in_a_bits_data;
    logic                  in_a_bits_corrupt;

    logic                  in_d_ready;
    logic                  in_d_valid;
    logic [2:0]            in_d_bits_opcode;
    logic [1:0]            in_d_bits_param;
    logic [3:0]            in_d_bits_size;
    logic [SOURCE_W-1:0]   in_d_bits_source;
    logic [SINK_W-1:0]     in_d_bits_sink;
    logic                  in_d_bits_denied;
    logic [DATA_W-1:0]     in_d_bits_data;
    logic                  in_d_bits_corrupt;

    modport master (
        input  in_a_ready,
        output in_a_valid, in_a_bits_opcode, in_a_bits_param, in_a_bits_size,
               in_a_bits_source, in_a_bits_address, in_a_bits_mask,
               in_a_bits_data, in_a_bits_corrupt,
        output in_d_ready,
        input  in_d_valid, in_d_bits_opcode, in_d_bits_param, in_d_bits_size,
               in_d_bits_source, in_d_bits_sink, in_d_bits_denied,
               in_d_bits_data, in_d_bits_corrupt
    );

    modport slave (
        output in_a_ready,
        input  in_a_valid, in_a_bits_opcode, in_a_bits_param, in_a_bits_size,
               in_a_bits_source, in_a_bits_address, in_a_bits_mask,
               in_a_bits_data, in_a_bits_corrupt,
        input  in_d_ready,
        output in_d_valid, in_d_bits_opcode, in_d_bits_param, in_d_bits_size,
               in_d_bits_source, in_d_bits_sink, in_d_bits_denied,
               in_d_bits_data, in_d_bits_corrupt
    );

endinterface

// File: rtl/tl_sram_bank.sv
// Single-port byte-lane SRAM: per-byte write enable, registered read, contents never reset.
module tl_sram_bank #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 512,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W/8-1:0] wmask,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int LANES = DATA_W / 8;

    // Each byte lane is its own array so every lane maps onto a plain RAM primitive.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_q;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        if (wmask[gi]) begin
                            lane_mem[addr] <= wdata[gi*8 +: 8];
                        end
                    end else begin
                        lane_rd_q <= lane_mem[addr];
                    end
                end
            end

            assign rdata[gi*8 +: 8] = lane_rd_q;
        end
    endgenerate

endmodule

// File: rtl/tl_sram_responder.sv
// TileLink-UH manager endpoint: serves Get/Put bursts and Hints from a local SRAM,
// denying out-of-range, misaligned, oversized and atomic requests.
module tl_sram_responder
    import tl_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 64,
    parameter int                SOURCE_W   = 1,
    parameter int                SINK_W     = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int                MEM_BYTES  = 4096,
    parameter int                MAX_LGSIZE = 6
) (
    input  logic          clock,
    input  logic          reset,
    tl_sram_responder_if.slave bus
);

    localparam int BYTES_W = DATA_W / 8;
    localparam int BEAT_SH = $clog2(BYTES_W);
    localparam int DEPTH   = MEM_BYTES / BYTES_W;
    localparam int MEM_AW  = $clog2(DEPTH);

    state_e                  state_q, state_d;
    logic [TL_BEAT_W-1:0]    beat_q, beat_d;
    logic [TL_OP_W-1:0]      opcode_q, opcode_d;
    logic [TL_SIZE_W-1:0]    size_q, size_d;
    logic [SOURCE_W-1:0]     source_q, source_d;
    logic [MEM_AW-1:0]       word_q, word_d;
    logic                    denied_q, denied_d;

    logic                    a_fire, d_fire, last_beat;
    logic [ADDR_W-1:0]       req_offset, req_align_mask;
    logic                    req_op_ok, req_denied;
    logic [MEM_AW-1:0]       req_word;

    logic                    mem_en, mem_we;
    logic [MEM_AW-1:0]       mem_addr;
    logic [BYTES_W-1:0]      mem_wmask;
    logic [DATA_W-1:0]       mem_wdata, mem_rdata;

    d_hdr_t                  d_hdr;
    logic [DATA_W-1:0]       d_data;
    logic [SOURCE_W-1:0]     d_source;
    logic                    unused_a_param;

    assign unused_a_param = ^bus.in_a_bits_param;

    assign bus.in_a_ready = (state_q == ST_IDLE) || (state_q == ST_WRITE);
    assign bus.in_d_valid = (state_q == ST_ACK)  || (state_q == ST_RD_RESP);
    assign a_fire         = bus.in_a_valid && bus.in_a_ready;
    assign d_fire         = bus.in_d_valid && bus.in_d_ready;
    assign last_beat      = (beat_q == (beats_from_size(size_q) - TL_BEAT_W'(1)));

    // Subtracting the base first lets a single unsigned compare cover both range ends.
    assign req_offset     = bus.in_a_bits_address - BASE_ADDR;
    assign req_align_mask = (ADDR_W'(1) << bus.in_a_bits_size) - ADDR_W'(1);
    assign req_word       = req_offset[BEAT_SH +: MEM_AW];
    assign req_op_ok      = (bus.in_a_bits_opcode == A_PUT_FULL)
                         || (bus.in_a_bits_opcode == A_PUT_PARTIAL)
                         || (bus.in_a_bits_opcode == A_GET)
                         || (bus.in_a_bits_opcode == A_HINT);
    assign req_denied     = !((req_offset < ADDR_W'(MEM_BYTES))
                           && (bus.in_a_bits_size <= 4'(MAX_LGSIZE))
                           && ((bus.in_a_bits_address & req_align_mask) == '0)
                           && req_op_ok);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            opcode_q <= '0;
            size_q   <= '0;
            source_q <= '0;
            word_q   <= '0;
            denied_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            opcode_q <= opcode_d;
            size_q   <= size_d;
            source_q <= source_d;
            word_q   <= word_d;
            denied_q <= denied_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        opcode_d  = opcode_q;
        size_d    = size_q;
        source_d  = source_q;
        word_d    = word_q;
        denied_d  = denied_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = word_q + MEM_AW'(beat_q);
        mem_wmask = bus.in_a_bits_mask;
        mem_wdata = bus.in_a_bits_data;

        unique case (state_q)
            ST_IDLE: begin
                if (a_fire) begin
                    opcode_d = bus.in_a_bits_opcode;
                    size_d   = bus.in_a_bits_size;
                    source_d = bus.in_a_bits_source;
                    word_d   = req_word;
                    denied_d = req_denied;
                    beat_d   = '0;
                    if (is_put(bus.in_a_bits_opcode)) begin
                        mem_en   = !req_denied && !bus.in_a_bits_corrupt;
                        mem_we   = mem_en;
                        mem_addr = req_word;
                        if (beats_from_size(bus.in_a_bits_size) == TL_BEAT_W'(1)) begin
                            state_d = ST_ACK;
                        end else begin
                            state_d = ST_WRITE;
                            beat_d  = TL_BEAT_W'(1);
                        end
                    end else if (bus.in_a_bits_opcode == A_HINT) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_WRITE: begin
                if (a_fire) begin
                    mem_en = !denied_q && !bus.in_a_bits_corrupt;
                    mem_we = mem_en;
                    if (last_beat) begin
                        state_d = ST_ACK;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + TL_BEAT_W'(1);
                    end
                end
            end
            ST_ACK: begin
                if (d_fire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                // Denied reads (including Arith/Logical) never touch the array.
                mem_en  = !denied_q;
                state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (d_fire) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                    end else begin
                        state_d = ST_RD_ISSUE;
                        beat_d  = beat_q + TL_BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // D bits are zero outside ACK/RD_RESP; the bank read register holds data while stalled.
    always_comb begin
        d_hdr    = '0;
        d_data   = '0;
        d_source = '0;
        if (state_q == ST_ACK) begin
            d_hdr.opcode = (opcode_q == A_HINT) ? D_HINT_ACK : D_ACCESS_ACK;
            d_hdr.size   = size_q;
            d_hdr.denied = denied_q;
            d_source     = source_q;
        end else if (state_q == ST_RD_RESP) begin
            d_hdr.opcode  = D_ACCESS_ACK_DATA;
            d_hdr.size    = size_q;
            d_hdr.denied  = denied_q;
            d_hdr.corrupt = denied_q;
            d_source      = source_q;
            d_data        = denied_q ? '0 : mem_rdata;
        end
    end

    assign bus.in_d_bits_opcode  = d_hdr.opcode;
    assign bus.in_d_bits_param   = d_hdr.param;
    assign bus.in_d_bits_size    = d_hdr.size;
    assign bus.in_d_bits_source  = d_source;
    assign bus.in_d_bits_sink    = '0;
    assign bus.in_d_bits_denied  = d_hdr.denied;
    assign bus.in_d_bits_data    = d_data;
    assign bus.in_d_bits_corrupt = d_hdr.corrupt;

    tl_sram_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_bank (
        .clk   (clock),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wmask (mem_wmask),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_tl_sram_responder.sv
// Directed bench for tl_sram_responder: puts, gets, bursts with D back-pressure,
// denied requests, hints and reset in the middle of a burst.
module tb_tl_sram_responder;
    import tl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clock = ~clock;

    tl_sram_responder_if #(.ADDR_W(32), .DATA_W(64), .SOURCE_W(1), .SINK_W(2)) bus ();

    tl_sram_responder #(
        .ADDR_W     (32),
        .DATA_W     (64),
        .SOURCE_W   (1),
        .SINK_W     (2),
        .BASE_ADDR  (32'h8000_0000),
        .MEM_BYTES  (4096),
        .MAX_LGSIZE (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one A beat and returns 1 time unit after the edge where it fired.
    task automatic a_send(input logic [2:0] op, input logic [3:0] sz, input logic src,
                          input logic [31:0] addr, input logic [7:0] mask,
                          input logic [63:0] data, input logic corrupt);
        int n = 0;
        bus.in_a_valid        = 1'b1;
        bus.in_a_bits_opcode  = op;
        bus.in_a_bits_size    = sz;
        bus.in_a_bits_source  = src;
        bus.in_a_bits_address = addr;
        bus.in_a_bits_mask    = mask;
        bus.in_a_bits_data    = data;
        bus.in_a_bits_corrupt = corrupt;
        while (!bus.in_a_ready && n < 50) begin
            tick();
            n++;
        end
        check("a_ready", {63'd0, bus.in_a_ready}, 64'd1);
        tick();
        bus.in_a_valid = 1'b0;
        $display("txn A op=%0d size=%0d src=%0d addr=0x%08h data=0x%016h", op, sz, src, addr, data);
    endtask

    // Waits for a D beat, checks every field, optionally stalls one cycle, then accepts it.
    task automatic d_expect(input string tag, input logic [2:0] op, input logic [3:0] sz,
                            input logic src, input logic denied, input logic [63:0] data,
                            input logic corrupt, input bit stall);
        int n = 0;
        while (!bus.in_d_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"},   {63'd0, bus.in_d_valid}, 64'd1);
        check({tag, "_opcode"},  {61'd0, bus.in_d_bits_opcode}, {61'd0, op});
        check({tag, "_size"},    {60'd0, bus.in_d_bits_size}, {60'd0, sz});
        check({tag, "_source"},  {63'd0, bus.in_d_bits_source}, {63'd0, src});
        check({tag, "_denied"},  {63'd0, bus.in_d_bits_denied}, {63'd0, denied});
        check({tag, "_corrupt"}, {63'd0, bus.in_d_bits_corrupt}, {63'd0, corrupt});
        check({tag, "_data"},    bus.in_d_bits_data, data);
        if (stall) begin
            tick();
            check({tag, "_stall_valid"}, {63'd0, bus.in_d_valid}, 64'd1);
            check({tag, "_stall_data"},  bus.in_d_bits_data, data);
        end
        $display("txn D %s op=%0d denied=%0d data=0x%016h", tag, bus.in_d_bits_opcode,
                 bus.in_d_bits_denied, bus.in_d_bits_data);
        bus.in_d_ready = 1'b1;
        tick();
        bus.in_d_ready = 1'b0;
    endtask

    initial begin
        bus.in_a_valid        = 1'b0;
        bus.in_a_bits_opcode  = '0;
        bus.in_a_bits_param   = '0;
        bus.in_a_bits_size    = '0;
        bus.in_a_bits_source  = '0;
        bus.in_a_bits_address = '0;
        bus.in_a_bits_mask    = '0;
        bus.in_a_bits_data    = '0;
        bus.in_a_bits_corrupt = 1'b0;
        bus.in_d_ready        = 1'b0;

        repeat (3) tick();
        check("rst_d_valid", {63'd0, bus.in_d_valid}, 64'd0);
        check("rst_a_ready", {63'd0, bus.in_a_ready}, 64'd1);
        check("rst_d_opcode", {61'd0, bus.in_d_bits_opcode}, 64'd0);
        check("rst_d_data", bus.in_d_bits_data, 64'd0);
        reset = 1'b1;
        tick();

        // Single-beat PutFull then Get: ack in the next cycle, data two cycles after Get.
        a_send(A_PUT_FULL, 4'd3, 1'b0, 32'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
        check("put1_lat", {63'd0, bus.in_d_valid}, 64'd1);
        d_expect("put1", D_ACCESS_ACK, 4'd3, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        a_send(A_GET, 4'd3, 1'b0, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
        check("get1_lat0", {63'd0, bus.in_d_valid}, 64'd0);
        tick();
        check("get1_lat1", {63'd0, bus.in_d_valid}, 64'd1);
        d_expect("get1", D_ACCESS_ACK_DATA, 4'd3, 1'b0, 1'b0, 64'h1122_3344_5566_7788, 1'b0, 1'b1);

        // PutPartial of the low four bytes.
        a_send(A_PUT_PARTIAL, 4'd3, 1'b0, 32'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0);
        d_expect("putp", D_ACCESS_ACK, 4'd3, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        a_send(A_GET, 4'd3, 1'b0, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
        d_expect("getp", D_ACCESS_ACK_DATA, 4'd3, 1'b0, 1'b0, 64'h1122_3344_BBBB_BBBB, 1'b0, 1'b0);

        // 64 B burst put: no D traffic until the eighth beat has fired.
        for (int i = 0; i < 8; i++) begin
            a_send(A_PUT_FULL, 4'd6, 1'b0, 32'h8000_0040 + 32'(i * 8), 8'hFF, 64'(i), 1'b0);
            check("burst_wr_dvalid", {63'd0, bus.in_d_valid}, (i == 7) ? 64'd1 : 64'd0);
        end
        d_expect("burst_ack", D_ACCESS_ACK, 4'd6, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        a_send(A_GET, 4'd6, 1'b0, 32'h8000_0040, 8'hFF, 64'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            d_expect("burst_rd", D_ACCESS_ACK_DATA, 4'd6, 1'b0, 1'b0, 64'(i), 1'b0, 1'b1);
        end
        check("burst_rd_done", {63'd0, bus.in_d_valid}, 64'd0);

        // Denied requests: out of range, oversized, and SRAM left intact.
        a_send(A_GET, 4'd3, 1'b0, 32'h9000_0000, 8'hFF, 64'd0, 1'b0);
        d_expect("den_range", D_ACCESS_ACK_DATA, 4'd3, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
        a_send(A_GET, 4'd7, 1'b0, 32'h8000_0000, 8'hFF, 64'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            d_expect("den_size", D_ACCESS_ACK_DATA, 4'd7, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
        end
        check("den_size_done", {63'd0, bus.in_d_valid}, 64'd0);
        a_send(A_GET, 4'd3, 1'b0, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
        d_expect("after_den", D_ACCESS_ACK_DATA, 4'd3, 1'b0, 1'b0, 64'h1122_3344_BBBB_BBBB, 1'b0, 1'b0);

        // Hint and Logical.
        a_send(A_HINT, 4'd3, 1'b1, 32'h8000_0000, 8'hFF, 64'd0, 1'b0);
        d_expect("hint", D_HINT_ACK, 4'd3, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
        a_send(A_LOGICAL, 4'd3, 1'b0, 32'h8000_0010, 8'hFF, 64'd0, 1'b0);
        d_expect("logical", D_ACCESS_ACK_DATA, 4'd3, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
        check("logical_done", {63'd0, bus.in_d_valid}, 64'd0);

        // Reset after three of eight put beats: transaction dropped, written beats kept.
        for (int i = 0; i < 3; i++) begin
            a_send(A_PUT_FULL, 4'd6, 1'b0, 32'h8000_0080, 8'hFF, 64'hA0 + 64'(i), 1'b0);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_d_valid", {63'd0, bus.in_d_valid}, 64'd0);
        check("mid_rst_a_ready", {63'd0, bus.in_a_ready}, 64'd1);
        tick();
        check("mid_rst_idle", {63'd0, bus.in_d_valid}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            a_send(A_GET, 4'd3, 1'b0, 32'h8000_0080 + 32'(i * 8), 8'hFF, 64'd0, 1'b0);
            d_expect("post_rst", D_ACCESS_ACK_DATA, 4'd3, 1'b0, 1'b0, 64'hA0 + 64'(i), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/tl_sram_responder.md
Name: tl_sram_responder

Overview:
- TileLink-UH manager (responder) endpoint: accepts A-channel requests from the system bus side of the interconnect coupler and returns D-channel responses.
- Backed by a local byte-enabled SRAM; multi-beat Get/Put bursts supported.
- Serves as the terminal slave for scratchpad memory behind the width-adapted 64-bit bus, i.e. the responder end of the A/D handshake the coupler initiates.

Parameters:
- ADDR_W, 32, A-channel address width
- DATA_W, 64, beat width in bits (8 bytes/beat)
- SOURCE_W, 1, source ID width
- SINK_W, 2, D sink width (driven 0)
- BASE_ADDR, 32'h8000_0000, first byte served
- MEM_BYTES, 4096, SRAM size (power of two, ≥64)
- MAX_LGSIZE, 6, largest legal lg2 transfer size (64 B = 8 beats)

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-low (0 = reset, sampled on rising clock)
- in_a_ready  out  1  A accept
- in_a_valid  in  1  A request valid
- in_a_bits_opcode  in  3  0 PutFull, 1 PutPartial, 2 Arith, 3 Logical, 4 Get, 5 Hint
- in_a_bits_param  in  3  ignored
- in_a_bits_size  in  4  lg2 bytes
- in_a_bits_source  in  SOURCE_W  requester ID
- in_a_bits_address  in  ADDR_W  byte address
- in_a_bits_mask  in  8  byte enables
- in_a_bits_data  in  DATA_W  put data
- in_a_bits_corrupt  in  1  beat poisoned
- in_d_ready  in  1  D accept
- in_d_valid  out  1  response valid
- in_d_bits_opcode  out  3  0 AccessAck, 1 AccessAckData, 2 HintAck
- in_d_bits_param  out  2  always 0
- in_d_bits_size  out  4  echo of request size
- in_d_bits_source  out  SOURCE_W  echo of request source
- in_d_bits_sink  out  SINK_W  always 0
- in_d_bits_denied  out  1  request rejected
- in_d_bits_data  out  DATA_W  read data (0 when denied)
- in_d_bits_corrupt  out  1  equals denied on AccessAckData, else 0

Behaviour:
- Reset (reset==0 at an edge): state IDLE, beat counter 0, in_d_valid 0, in_a_ready 1 after release; all D bits 0. Reset mid-burst aborts the transaction: no response, SRAM keeps already-written beats.
- beats = (size ≤ 3) ? 1 : 1 << (size − 3). Beat address = (first address with low lg2(DATA_W/8) bits cleared) + 8·beat_idx, wrapping inside MEM_BYTES.
- Legal request: address − BASE_ADDR < MEM_BYTES, size ≤ MAX_LGSIZE, address aligned to size, opcode ∈ {0, 1, 4, 5}. Anything else is denied.
- States: IDLE, WRITE, ACK, RD_ISSUE, RD_RESP.
- in_a_ready = 1 only in IDLE and WRITE. in_d_valid = 1 only in ACK and RD_RESP. A and D never fire in the same cycle.
- IDLE, A fire: latch opcode, size, source, address, denied.
  - Put: beat 0 is written this cycle unless denied or corrupt. If beats==1 go to ACK, else go to WRITE with counter = 1.
  - Get/Arith/Logical: go to RD_ISSUE.
  - Hint: go to ACK.
- WRITE: each A fire writes the next beat (byte-enabled by mask; skipped if denied or corrupt). Address, size and opcode of later beats are ignored. The last beat goes to ACK. No D traffic during WRITE.
- ACK: drive AccessAck, or HintAck for Hint, with latched denied. Hold until in_d_ready, then go to IDLE.
- RD_ISSUE: drive SRAM read of the current beat (1-cycle sync read), go to RD_RESP.
- RD_RESP: AccessAckData, data = SRAM output captured into a register (0 if denied); denied and corrupt both reflect the latch.
  - D bits stay stable while stalled.
  - On D fire: last beat → IDLE, else counter+1 → RD_ISSUE.
  - Read throughput is one beat per 2 cycles.
- Latency:
  - Get fired at edge T → d_valid in cycle T+2.
  - Single-beat Put fired at T → d_valid in cycle T+1.
  - Burst Put → d_valid the cycle after its final beat fires.
- Arith/Logical are always denied: respond with `beats` AccessAckData beats, denied = corrupt = 1, data 0, no SRAM access.

Decomposition:
- Shared package tl_pkg: A/D opcode constants, width constants, beats-from-size function, D response struct.
- Sub-module tl_sram_bank: depth MEM_BYTES/8, DATA_W wide, per-byte write enable, registered read, no reset on contents.

Test Plan:
- PutFull 0x8000_0010, size 3, data 0x1122334455667788, mask 0xFF; then Get same → AccessAck denied 0, then AccessAckData with 0x1122334455667788, d_valid 2 cycles after Get fire.
- PutPartial mask 0x0F data 0xAAAA_AAAA_BBBB_BBBB over the above → Get returns 0x11223344BBBBBBBB.
- 64 B Put burst (size 6, 8 beats, data = beat idx) at 0x8000_0040, then Get size 6 with d_ready toggled 1/0 → 8 beats 0..7 in order, data stable while stalled, one AccessAck only after beat 8.
- Get at 0x9000_0000 and Get size 7 → AccessAckData denied 1, corrupt 1, data 0 (1 beat and 16 beats respectively); SRAM unchanged.
- Hint source 1 → HintAck, source 1, denied 0; Logical size 3 → single AccessAckData denied 1.
- Assert reset (0) after 3 of 8 Put beats → d_valid 0 and a_ready 1 after release; a new Get succeeds; beats 0..2 are present in SRAM.
